// File: rtl/instruction_fetcher.sv
// -----------------------------------------------------------------------------
// instruction_fetcher
//   Fetches instructions one at a time from the memory controller and buffers
//   them, with their addresses, in an IQ_DEPTH-entry FIFO for the decoder.
//   JAL targets are followed immediately. Every other instruction, including
//   branches, advances the fetch address by 4. roll_back flushes the queue and
//   redirects fetch. rdy_in=0 freezes the whole block.
//
// Parameters
//   IQ_DEPTH  queue entry count (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk_in             system clock, rising edge
//   rst_in             asynchronous active-low reset
//   rdy_in             global stall when low
//   roll_back          flush request
//   roll_back_pc       redirect target
//   fetch_start        fetch request to memory controller (1 only in REQ)
//   pc                 fetch address
//   finish_fetch       one-cycle fetch-complete pulse
//   instruction_in     returned instruction
//   instruction_pc_in  address the returned instruction belongs to
//   iq_pop             decoder consumes the head entry
//   iq_inst / iq_pc    head entry (valid when iq_empty is 0)
//   iq_empty / iq_full queue occupancy flags
// -----------------------------------------------------------------------------
module instruction_fetcher #(
   parameter int unsigned IQ_DEPTH = 16,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        roll_back,
   input  logic [31:0] roll_back_pc,
   output logic        fetch_start,
   output logic [31:0] pc,
   input  logic        finish_fetch,
   input  logic [31:0] instruction_in,
   input  logic [31:0] instruction_pc_in,
   input  logic        iq_pop,
   output logic [31:0] iq_inst,
   output logic [31:0] iq_pc,
   output logic        iq_empty,
   output logic        iq_full
);

   localparam int unsigned PTR_W = $clog2(IQ_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(IQ_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLD
   } state_t;

   state_t state, state_next;

   // Target is computed while instruction_in is valid at acceptance, then
   // held here until HOLD ends and pc is allowed to move.
   logic [31:0]      pc_next_q;
   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;
   logic [31:0]      mem_inst [IQ_DEPTH];
   logic [31:0]      mem_pc   [IQ_DEPTH];

   logic        accept;
   logic        pop;
   logic [31:0] jal_imm;
   logic [31:0] fetch_target;

   assign fetch_start = (state == REQ);
   assign iq_empty    = (count == '0);
   assign iq_full     = (count == FULL_COUNT);
   assign iq_inst     = mem_inst[head];
   assign iq_pc       = mem_pc[head];

   // roll_back outranks acceptance and pop; rdy_in outranks everything.
   assign accept = rdy_in && !roll_back && (state == REQ) && finish_fetch
                   && (instruction_pc_in == pc);
   assign pop    = rdy_in && !roll_back && iq_pop && !iq_empty;

   assign jal_imm      = {{12{instruction_in[31]}}, instruction_in[19:12],
                          instruction_in[20], instruction_in[30:21], 1'b0};
   assign fetch_target = (instruction_in[6:0] == 7'b1101111) ? pc + jal_imm
                                                             : pc + 32'd4;

   always_comb begin
      state_next = state;
      if (roll_back) begin
         state_next = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (!iq_full) state_next = REQ;
            REQ:     if (accept)   state_next = HOLD;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         pc_next_q <= RESET_PC;
      end else if (rdy_in) begin
         state <= state_next;
         if (roll_back) begin
            pc <= roll_back_pc;
         end else if (state == HOLD) begin
            pc <= pc_next_q;
         end
         if (accept) begin
            pc_next_q <= fetch_target;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (rdy_in) begin
         if (roll_back) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (accept) tail <= tail + PTR_W'(1);
            if (pop)    head <= head + PTR_W'(1);
            if (accept && !pop) begin
               count <= count + CNT_W'(1);
            end else if (pop && !accept) begin
               count <= count - CNT_W'(1);
            end
         end
      end
   end

   // Storage needs no reset: entries are only visible once counted.
   always_ff @(posedge clk_in) begin
      if (accept) begin
         mem_inst[tail] <= instruction_in;
         mem_pc[tail]   <= pc;
      end
   end

endmodule

// File: tb/tb_instruction_fetcher.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetcher
//   Bench for instruction_fetcher: directed scenarios followed by a randomized
//   phase, compared against a transaction-level reference (a queue of
//   {instruction, address} plus the expected next fetch address).
// -----------------------------------------------------------------------------
module tb_instruction_fetcher;

   localparam int unsigned DEPTH  = 16;
   localparam logic [31:0] RST_PC = 32'h0;
   localparam logic [31:0] NOP    = 32'h00000013;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in = 1'b1;
   logic        roll_back = 1'b0;
   logic [31:0] roll_back_pc = '0;
   logic        fetch_start;
   logic [31:0] pc;
   logic        finish_fetch = 1'b0;
   logic [31:0] instruction_in = '0;
   logic [31:0] instruction_pc_in = '0;
   logic        iq_pop = 1'b0;
   logic [31:0] iq_inst;
   logic [31:0] iq_pc;
   logic        iq_empty;
   logic        iq_full;

   int checks   = 0;
   int failures = 0;

   logic [63:0] model_q[$];
   logic [31:0] exp_pc;

   always #5 clk_in = ~clk_in;

   instruction_fetcher #(
      .IQ_DEPTH (DEPTH),
      .RESET_PC (RST_PC)
   ) dut (
      .clk_in            (clk_in),
      .rst_in            (rst_in),
      .rdy_in            (rdy_in),
      .roll_back         (roll_back),
      .roll_back_pc      (roll_back_pc),
      .fetch_start       (fetch_start),
      .pc                (pc),
      .finish_fetch      (finish_fetch),
      .instruction_in    (instruction_in),
      .instruction_pc_in (instruction_pc_in),
      .iq_pop            (iq_pop),
      .iq_inst           (iq_inst),
      .iq_pc             (iq_pc),
      .iq_empty          (iq_empty),
      .iq_full           (iq_full)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Next fetch address from the instruction-set rules: JAL adds its signed
   // 21-bit offset, everything else falls through by 4.
   function automatic logic [31:0] ref_next(input logic [31:0] a, input logic [31:0] i);
      int off;
      if (i[6:0] != 7'h6F) return a + 32'd4;
      off = int'(i[30:21]) * 2 + int'(i[20]) * 2048 + int'(i[19:12]) * 4096;
      if (i[31]) off = off - (1 << 20);
      return a + 32'(off);
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check_head(input string tag);
      check({tag, "_empty"}, 32'(iq_empty), 32'(model_q.size() == 0));
      check({tag, "_full"},  32'(iq_full),  32'(model_q.size() == DEPTH));
      if (model_q.size() != 0) begin
         check({tag, "_inst"}, iq_inst, model_q[0][63:32]);
         check({tag, "_pc"},   iq_pc,   model_q[0][31:0]);
      end
   endtask

   task automatic wait_req(input string tag);
      int n;
      n = 0;
      while (!fetch_start && n < 60) begin
         tick();
         n++;
      end
      check({tag, "_req_seen"}, 32'(fetch_start), 32'd1);
      check({tag, "_req_pc"}, pc, exp_pc);
   endtask

   task automatic serve_one(input string tag, input logic [31:0] inst, input logic do_pop);
      logic [31:0] req_pc;
      bit popped;
      wait_req(tag);
      req_pc = exp_pc;
      if (do_pop) check_head({tag, "_prepop"});
      popped = do_pop && (model_q.size() != 0);
      finish_fetch      = 1'b1;
      instruction_in    = inst;
      instruction_pc_in = req_pc;
      iq_pop            = do_pop;
      tick();
      finish_fetch = 1'b0;
      iq_pop       = 1'b0;
      if (popped) void'(model_q.pop_front());
      model_q.push_back({inst, req_pc});
      exp_pc = ref_next(req_pc, inst);
      check({tag, "_hold_fs"}, 32'(fetch_start), 32'd0);
      check({tag, "_hold_pc"}, pc, req_pc);
      check_head(tag);
   endtask

   task automatic pop_one(input string tag);
      check_head(tag);
      iq_pop = 1'b1;
      tick();
      iq_pop = 1'b0;
      if (model_q.size() != 0) void'(model_q.pop_front());
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] held_pc;
      logic [31:0] old_pc;
      bit          acc;
      int          accepts;

      // Reset values
      #1 rst_in = 1'b0;
      #2;
      check("rst_fetch_start", 32'(fetch_start), 32'd0);
      check("rst_pc",          pc,               RST_PC);
      check("rst_empty",       32'(iq_empty),    32'd1);
      check("rst_full",        32'(iq_full),     32'd0);
      tick();
      tick();
      rst_in = 1'b1;
      exp_pc = RST_PC;
      model_q.delete();

      // First fetch, fall-through, then JAL
      serve_one("first", NOP, 1'b0);
      check("first_iq_pc",   iq_pc,   32'h0);
      check("first_iq_inst", iq_inst, 32'h13);
      wait_req("second");
      check("second_pc_lit", pc, 32'h4);
      serve_one("second", NOP, 1'b0);
      serve_one("jal", 32'h0100006F, 1'b0);
      wait_req("after_jal");
      check("after_jal_pc_lit", pc, 32'h18);

      // Count 5 with simultaneous push and pop, then drain in order
      serve_one("fill4", NOP, 1'b0);
      serve_one("fill5", NOP, 1'b0);
      serve_one("pushpop", NOP, 1'b1);
      for (int i = 0; i < 5; i++) pop_one("drain");
      check_head("drained");
      check("drained_empty_lit", 32'(iq_empty), 32'd1);

      // Stall mid-request with a response pulsed during the stall
      wait_req("stall");
      held_pc           = pc;
      rdy_in            = 1'b0;
      finish_fetch      = 1'b1;
      instruction_pc_in = held_pc;
      instruction_in    = NOP;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_fs",    32'(fetch_start), 32'd1);
         check("stall_pc",    pc,               held_pc);
         check("stall_empty", 32'(iq_empty),    32'd1);
      end
      rdy_in       = 1'b1;
      finish_fetch = 1'b0;
      tick();
      check("post_stall_fs",    32'(fetch_start), 32'd1);
      check("post_stall_empty", 32'(iq_empty),    32'd1);

      // Response carrying the wrong address is discarded
      finish_fetch      = 1'b1;
      instruction_pc_in = held_pc + 32'd4;
      tick();
      finish_fetch = 1'b0;
      check("mismatch_fs",    32'(fetch_start), 32'd1);
      check("mismatch_pc",    pc,               held_pc);
      check("mismatch_empty", 32'(iq_empty),    32'd1);

      // Fill to DEPTH without popping
      for (int i = 0; i < DEPTH; i++) begin
         r = $urandom();
         r[6:0] = 7'h13;
         serve_one("fill", r, 1'b0);
      end
      check("full_flag", 32'(iq_full), 32'd1);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("full_no_fetch", 32'(fetch_start), 32'd0);
      end
      pop_one("full_pop");
      wait_req("resume");

      // Flush, rebuild 3 entries, then flush with an outstanding request
      roll_back    = 1'b1;
      roll_back_pc = 32'h40;
      tick();
      roll_back = 1'b0;
      model_q.delete();
      exp_pc = 32'h40;
      check("flush1_empty", 32'(iq_empty),    32'd1);
      check("flush1_fs",    32'(fetch_start), 32'd0);
      check("flush1_pc",    pc,               32'h40);
      for (int i = 0; i < 3; i++) serve_one("rb_fill", NOP, 1'b0);
      wait_req("rb_out");
      old_pc            = pc;
      roll_back         = 1'b1;
      roll_back_pc      = 32'h100;
      finish_fetch      = 1'b1;
      instruction_pc_in = old_pc;
      instruction_in    = NOP;
      iq_pop            = 1'b1;
      tick();
      roll_back = 1'b0;
      iq_pop    = 1'b0;
      model_q.delete();
      exp_pc = 32'h100;
      check("flush2_empty", 32'(iq_empty),    32'd1);
      check("flush2_fs",    32'(fetch_start), 32'd0);
      check("flush2_pc",    pc,               32'h100);
      tick();
      finish_fetch = 1'b0;
      check("late_drop_empty", 32'(iq_empty), 32'd1);
      check("late_drop_fs",    32'(fetch_start), 32'd1);
      check("late_drop_pc",    pc,              32'h100);
      tick();
      check("late_drop_empty2", 32'(iq_empty), 32'd1);

      // Reset asserted mid-request abandons it
      serve_one("pre_rst", NOP, 1'b0);
      serve_one("pre_rst", NOP, 1'b0);
      wait_req("rst_mid");
      old_pc            = pc;
      finish_fetch      = 1'b1;
      instruction_pc_in = old_pc;
      #2 rst_in = 1'b0;
      #1;
      check("rst_mid_fs",    32'(fetch_start), 32'd0);
      check("rst_mid_pc",    pc,               RST_PC);
      check("rst_mid_empty", 32'(iq_empty),    32'd1);
      tick();
      rst_in = 1'b1;
      model_q.delete();
      exp_pc = RST_PC;
      tick();
      check("rst_rel_empty", 32'(iq_empty), 32'd1);
      tick();
      check("rst_rel_empty2", 32'(iq_empty), 32'd1);
      finish_fetch = 1'b0;

      // Randomized traffic
      accepts = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (fetch_start) check("rnd_pc", pc, exp_pc);
         check_head("rnd");
         rdy_in       = ($urandom_range(0, 7) != 0);
         roll_back    = ($urandom_range(0, 39) == 0);
         roll_back_pc = 32'($urandom_range(0, 1023)) << 2;
         iq_pop       = 1'($urandom_range(0, 1));
         r = $urandom();
         r[6:0] = ($urandom_range(0, 2) == 0) ? 7'h6F : 7'h13;
         instruction_in    = r;
         finish_fetch      = (fetch_start && $urandom_range(0, 2) == 0)
                             || ($urandom_range(0, 15) == 0);
         instruction_pc_in = ($urandom_range(0, 4) == 0) ? exp_pc + 32'd4 : exp_pc;
         if (rdy_in) begin
            if (roll_back) begin
               model_q.delete();
               exp_pc = roll_back_pc;
            end else begin
               acc = fetch_start && finish_fetch && (instruction_pc_in == exp_pc);
               if (iq_pop && model_q.size() != 0) void'(model_q.pop_front());
               if (acc) begin
                  model_q.push_back({instruction_in, exp_pc});
                  exp_pc = ref_next(exp_pc, instruction_in);
                  accepts++;
               end
            end
         end
         tick();
      end
      rdy_in       = 1'b1;
      roll_back    = 1'b0;
      iq_pop       = 1'b0;
      finish_fetch = 1'b0;
      check("rnd_made_progress", 32'(accepts > 20), 32'd1);
      check_head("rnd_end");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instruction_fetcher.md
INSTRUCTION_FETCHER -- requirements
Module: instruction_fetcher

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset.
REQ-002 Parameter IQ_DEPTH, default 16, SHALL set the instruction queue entry count (power of two, >=2).
REQ-003 Parameter RESET_PC, default 32'h0, SHALL set the first fetch address.
REQ-004 clk_in  input  1  system clock; all state SHALL update on its rising edge.
REQ-005 rst_in  input  1  asynchronous active-low reset.
REQ-006 rdy_in  input  1  when low, the block SHALL hold all state and outputs.
REQ-007 roll_back  input  1  mispredict flush request.
REQ-008 roll_back_pc  input  32  redirect target.
REQ-009 fetch_start  output  1  fetch request to the memory controller.
REQ-010 pc  output  32  fetch address.
REQ-011 finish_fetch  input  1  one-cycle fetch-complete pulse from the memory controller.
REQ-012 instruction_in  input  32  fetched instruction.
REQ-013 instruction_pc_in  input  32  address the returned instruction belongs to.
REQ-014 iq_pop  input  1  decoder consumes the head entry.
REQ-015 iq_inst  output  32  head instruction, valid when iq_empty is 0.
REQ-016 iq_pc  output  32  head instruction address.
REQ-017 iq_empty  output  1  queue holds 0 entries.
REQ-018 iq_full  output  1  queue holds IQ_DEPTH entries.

Function
REQ-019 The FSM SHALL have states IDLE, REQ and HOLD; fetch_start SHALL be 1 only in REQ.
REQ-020 IDLE->REQ SHALL occur when the queue is not full; otherwise the FSM SHALL remain in IDLE.
REQ-021 In REQ, pc SHALL stay constant and fetch_start SHALL stay 1 until finish_fetch is accepted.
REQ-022 A response SHALL be accepted only when finish_fetch=1 and instruction_pc_in==pc.
REQ-023 A finish_fetch with a mismatched instruction_pc_in SHALL be discarded with no state change.
REQ-024 Acceptance SHALL push {instruction_in, pc} into the queue and move the FSM to HOLD.
REQ-025 HOLD SHALL last exactly one cycle with fetch_start=0 and pc unchanged, then load the next pc and go to IDLE.
REQ-026 Next pc SHALL be pc + sign-extended J-immediate when instruction_in[6:0]==7'b1101111 (JAL).
REQ-027 For any other instruction, next pc SHALL be pc+4; branches are predicted not-taken; 32-bit addition wraps modulo 2^32.
REQ-028 At most one fetch SHALL be outstanding, so a push never overflows the queue.
REQ-029 Pop SHALL occur when iq_pop=1 and iq_empty=0; pop while empty SHALL be ignored.
REQ-030 Simultaneous push and pop SHALL leave the count unchanged and preserve FIFO order.
REQ-031 Head and tail pointers SHALL wrap at IQ_DEPTH; iq_inst and iq_pc SHALL reflect the head entry combinationally.
REQ-032 roll_back=1 (with rdy_in=1) SHALL empty the queue, load pc<=roll_back_pc and force IDLE.
REQ-033 roll_back SHALL take priority over any same-cycle push, pop or acceptance.
REQ-034 rdy_in=0 SHALL take priority over roll_back and all other events.

Reset
REQ-035 Reset SHALL asynchronously force state=IDLE, pc=RESET_PC, fetch_start=0, count=0, iq_empty=1, iq_full=0 and both pointers=0.
REQ-036 Reset asserted mid-request SHALL abandon the request; no response SHALL be pushed after release.

Verification
REQ-037 Release reset; return 32'h00000013 for pc 0 -> fetch_start=1 with pc=0; after the push iq_pc=0, iq_inst=32'h13; next request has pc=4.
REQ-038 Return 32'h0100006F (jal x0,16) at pc 32'h8 -> the next request has pc=32'h18.
REQ-039 Never pop, IQ_DEPTH=16 -> after 16 pushes iq_full=1 and fetch_start stays 0; one pop -> fetch resumes.
REQ-040 Queue holds 3 entries with a request outstanding; roll_back with roll_back_pc=32'h100 -> next cycle iq_empty=1, the late old-pc finish_fetch is dropped, the next request has pc=32'h100.
REQ-041 Count 5 with same-cycle push and pop -> count stays 5; pops return entries in push order.
REQ-042 rdy_in=0 for 3 cycles mid-request, with finish_fetch pulsed during the stall -> all outputs frozen and the response is not accepted.
